// File: rtl/contador_programable.sv
// -----------------------------------------------------------------------------
// contador_programable
//
// Parametrised up/down counter used as timer/sequencer beside the control FSM.
// The FSM loads it, enables it and reacts to the registered done pulse.
//
// Optional build macro: CONTADOR_PRESCALER_EN
//   When defined, a prescaler makes only every PRESC-th enabled cycle a step,
//   and the extra output 'tick' marks the cycles on which a step happens.
//
// Parameters:
//   BITS     counter width
//   RST_VAL  value of cuenta after reset (all ones by default)
//   PRESC    prescale ratio, >= 1 (only with CONTADOR_PRESCALER_EN)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous reset, active low
//   EN        count enable
//   load      synchronous load strobe (wins over EN)
//   load_val  value written to cuenta on load
//   lim       reload value when counting down, terminal value when counting up
//   dir       0 = down, 1 = up
//   mode      0 = wrap/reload, 1 = one-shot
//   cuenta    current count (registered)
//   tc        terminal count flag (combinational from cuenta, dir, lim)
//   done      one-cycle pulse following a terminal step (registered)
//   activo    high while the FSM is in CUENTA
//   tick      high on cycles where a step occurs (prescaler build only)
// -----------------------------------------------------------------------------
module contador_programable #(
  parameter int unsigned     BITS    = 3,
  parameter logic [BITS-1:0] RST_VAL = {BITS{1'b1}}
`ifdef CONTADOR_PRESCALER_EN
  ,
  parameter int unsigned     PRESC   = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EN,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic [BITS-1:0] lim,
  input  logic            dir,
  input  logic            mode,
  output logic [BITS-1:0] cuenta,
  output logic            tc,
  output logic            done,
  output logic            activo
`ifdef CONTADOR_PRESCALER_EN
  ,
  output logic            tick
`endif
);

  typedef enum logic {
    CUENTA = 1'b0,
    FIN    = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [BITS-1:0] cuenta_reg, cuenta_next;
  logic            done_reg, done_next;
  logic            step;

  // ---------------------------------------------------------------------------
  // Terminal count detection: bitwise equality against lim for the up
  // direction, zero detect for the down direction.
  // ---------------------------------------------------------------------------
  logic [BITS-1:0] lim_match;
  logic            at_zero;
  logic            at_lim;

  for (genvar gi = 0; gi < BITS; gi++) begin : g_lim_match
    assign lim_match[gi] = ~(cuenta_reg[gi] ^ lim[gi]);
  end

  assign at_zero = (cuenta_reg == '0);
  assign at_lim  = &lim_match;
  assign tc      = dir ? at_lim : at_zero;

`ifdef CONTADOR_PRESCALER_EN
  // ---------------------------------------------------------------------------
  // Prescaler: counts enabled cycles in CUENTA; the PRESC-th one is a step.
  // Cleared by reset and load, frozen while EN is low or in FIN.
  // ---------------------------------------------------------------------------
  localparam int unsigned PW = $clog2(PRESC) + 1;

  logic [PW-1:0] presc_reg, presc_next;
  logic          presc_run;

  assign presc_run = rst && !load && EN && (state_reg == CUENTA);
  assign step      = presc_run && (presc_reg == PW'(PRESC - 1));
  assign tick      = step;

  always_comb begin
    presc_next = presc_reg;
    if (load) begin
      presc_next = '0;
    end else if (step) begin
      presc_next = '0;
    end else if (presc_run) begin
      presc_next = presc_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end
`else
  // Without the prescaler every enabled, non-load cycle in CUENTA is a step.
  assign step = EN && !load && (state_reg == CUENTA);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cuenta_next = cuenta_reg;
    done_next   = 1'b0;

    if (load) begin
      cuenta_next = load_val;
      state_next  = CUENTA;
    end else if (step) begin
      if (!tc) begin
        cuenta_next = dir ? (cuenta_reg + BITS'(1)) : (cuenta_reg - BITS'(1));
      end else begin
        // Terminal step: done is registered alongside the step itself.
        done_next = 1'b1;
        if (!mode) begin
          cuenta_next = dir ? '0 : lim;
        end else begin
          state_next = FIN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= CUENTA;
      cuenta_reg <= RST_VAL;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cuenta_reg <= cuenta_next;
      done_reg   <= done_next;
    end
  end

  assign cuenta = cuenta_reg;
  assign done   = done_reg;
  assign activo = (state_reg == CUENTA);

endmodule

// File: tb/tb_contador_programable.sv
// -----------------------------------------------------------------------------
// Testbench for contador_programable (BITS=3). Directed sequences from the test
// plan followed by a randomized phase, all checked cycle by cycle against an
// arithmetic reference model. Works with or without CONTADOR_PRESCALER_EN.
// -----------------------------------------------------------------------------
module tb_contador_programable;

  localparam int BITS = 3;
  localparam int MOD  = 8;
  localparam int RSTV = 7;
`ifdef CONTADOR_PRESCALER_EN
  localparam int PF = 4;
`else
  localparam int PF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       EN = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] lim = '0;
  logic       dir = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] cuenta;
  logic       tc;
  logic       done;
  logic       activo;
`ifdef CONTADOR_PRESCALER_EN
  logic       tick;
`endif

  contador_programable #(
    .BITS(BITS)
`ifdef CONTADOR_PRESCALER_EN
    ,
    .PRESC(PF)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .EN(EN),
    .load(load),
    .load_val(load_val),
    .lim(lim),
    .dir(dir),
    .mode(mode),
    .cuenta(cuenta),
    .tc(tc),
    .done(done),
    .activo(activo)
`ifdef CONTADOR_PRESCALER_EN
    ,
    .tick(tick)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_cnt  = RSTV;
  bit m_fin  = 1'b0;
  bit m_done = 1'b0;
  int m_pre  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_tc();
    return (dir == 1'b0) ? (m_cnt == 0) : (m_cnt == int'(lim));
  endfunction

  // One clock cycle with the inputs currently driven; model advances, DUT is
  // compared #1 after the edge. One line printed per cycle.
  task automatic cycle(input string tag);
    bit stp;
    int nc;
    bit nf;
    bit nd;
    #1;
    stp = 1'b0;
    if (rst && !load && !m_fin && EN) begin
      stp = ((m_pre + 1) == PF);
    end
`ifdef CONTADOR_PRESCALER_EN
    chk({tag, "_tick"}, 32'(tick), 32'(stp));
`endif
    nc = m_cnt;
    nf = m_fin;
    nd = 1'b0;
    if (!rst) begin
      nc = RSTV; nf = 1'b0; m_pre = 0;
    end else if (load) begin
      nc = int'(load_val); nf = 1'b0; m_pre = 0;
    end else if (!m_fin && EN) begin
      m_pre = stp ? 0 : m_pre + 1;
      if (stp) begin
        if (!model_tc()) begin
          nc = dir ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
        end else begin
          nd = 1'b1;
          if (!mode) nc = dir ? 0 : int'(lim);
          else       nf = 1'b1;
        end
      end
    end
    m_cnt = nc; m_fin = nf; m_done = nd;
    @(posedge clk);
    #1;
    chk({tag, "_cuenta"}, 32'(cuenta), 32'(m_cnt));
    chk({tag, "_done"},   32'(done),   32'(m_done));
    chk({tag, "_activo"}, 32'(activo), 32'(!m_fin));
    chk({tag, "_tc"},     32'(tc),     32'(model_tc()));
    $display("[%0t] %s rst=%0b load=%0b EN=%0b dir=%0b mode=%0b lim=%0d -> cuenta=%0d done=%0b activo=%0b tc=%0b",
             $time, tag, rst, load, EN, dir, mode, lim, cuenta, done, activo, tc);
  endtask

  task automatic do_load(input logic [2:0] v, input string tag);
    load = 1'b1; load_val = v;
    cycle(tag);
    load = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b0; EN = 1'b0; load = 1'b0;
    cycle("reset");
    rst = 1'b1;
    chk("reset_cuenta_const", 32'(cuenta), 32'd7);
    chk("reset_activo_const", 32'(activo), 32'd1);

    // Count down 7 -> 0
    EN = 1'b1; dir = 1'b0; mode = 1'b0; lim = 3'd7;
    for (int i = 0; i < 7 * PF; i++) cycle("down");
    chk("down_end_const", 32'(cuenta), 32'd0);
    chk("down_tc_const",  32'(tc),     32'd1);

    // Wrap down with lim=5 from 2
    EN = 1'b0; lim = 3'd5;
    do_load(3'd2, "wrap_load");
    chk("wrap_load_const", 32'(cuenta), 32'd2);
    EN = 1'b1;
    for (int i = 0; i < 5 * PF; i++) cycle("wrap");

    // One-shot up to 3
    EN = 1'b0; lim = 3'd3; mode = 1'b1; dir = 1'b1;
    do_load(3'd0, "os_load");
    EN = 1'b1;
    for (int i = 0; i < 4 * PF; i++) cycle("os_up");
    for (int i = 0; i < 5 * PF; i++) begin
      dir = 1'(i % 2); mode = 1'(i % 3 == 0);
      cycle("os_fin");
    end
    chk("os_fin_cuenta_const", 32'(cuenta), 32'd3);
    chk("os_fin_activo_const", 32'(activo), 32'd0);
    dir = 1'b1; mode = 1'b1;
    do_load(3'd6, "os_reload");
    chk("os_reload_const", 32'(cuenta), 32'd6);
    chk("os_reload_activo_const", 32'(activo), 32'd1);

    // Priority: load over EN, reset over load
    EN = 1'b1; dir = 1'b0; mode = 1'b0;
    do_load(3'd4, "prio_load");
    chk("prio_load_const", 32'(cuenta), 32'd4);
    rst = 1'b0; load = 1'b1; load_val = 3'd1;
    cycle("prio_rst");
    chk("prio_rst_const", 32'(cuenta), 32'd7);
    rst = 1'b1; load = 1'b0;

    // Up past the limit: 6,7,0,1,2,0
    EN = 1'b0; lim = 3'd2; dir = 1'b1; mode = 1'b0;
    do_load(3'd6, "uplim_load");
    EN = 1'b1;
    for (int i = 0; i < 5 * PF; i++) cycle("uplim");

`ifdef CONTADOR_PRESCALER_EN
    // EN gaps mid-period stall the prescaler
    dir = 1'b0; EN = 1'b0;
    do_load(3'd7, "pre_load");
    EN = 1'b1; cycle("pre_a"); cycle("pre_b");
    EN = 1'b0; cycle("pre_gap"); cycle("pre_gap");
    EN = 1'b1;
    for (int i = 0; i < 6; i++) cycle("pre_c");
`endif

    // lim=0 down wrap: done every step
    EN = 1'b0; lim = 3'd0; dir = 1'b0; mode = 1'b0;
    do_load(3'd0, "lim0_load");
    EN = 1'b1;
    for (int i = 0; i < 3 * PF; i++) cycle("lim0");

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = 3'($urandom);
      EN       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) dir  = ~dir;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) lim  = 3'($urandom);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/contador_programable.md
Name: contador_programable

Overview:
Parametrised up/down counter for the state-machine datapath, successor to the fixed 3-bit down counter with enable.
- Adds width and reset-value parameters, a synchronous parallel load, a direction select and a programmable limit.
- Selectable wrap (reload) or one-shot mode, a terminal-count flag and a registered done pulse.
- Sits beside the control FSM as its timer/sequencer; the FSM loads it, enables it and reacts to done.

Parameters:
BITS, 3, counter width in bits
RST_VAL, 2**BITS-1, value of cuenta after reset (7 for BITS=3)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low; sampled only at posedge clk
EN  input  1  count enable; one step per cycle while high
load  input  1  synchronous load strobe
load_val  input  BITS  value written to cuenta on load
lim  input  BITS  limit: reload value when counting down, terminal value when counting up
dir  input  1  0 = count down, 1 = count up
mode  input  1  0 = wrap/reload, 1 = one-shot
cuenta  output  BITS  current count (registered)
tc  output  1  terminal count flag (combinational from state)
done  output  1  one-cycle pulse, registered
activo  output  1  1 while in state CUENTA

Behaviour:
- Reset: rst==0 at posedge clk sets:
  - cuenta=RST_VAL, state=CUENTA, done=0.
  - rst is synchronous only; no asynchronous effect.
- Priority per edge: rst > load > EN step > hold.
- FSM states:
  - CUENTA: counting allowed.
  - FIN: one-shot expired; cuenta frozen.
- load=1 (any state):
  - cuenta<=load_val, state<=CUENTA, done<=0.
  - EN is ignored that cycle.
- tc = (dir==0 && cuenta==0) || (dir==1 && cuenta==lim).
  - Valid in both states; purely a function of cuenta, dir and lim.
- Step in CUENTA with EN=1, load=0:
  - tc==0: cuenta <= cuenta-1 (dir=0) or cuenta+1 (dir=1), modulo 2**BITS.
  - tc==1, mode=0: cuenta <= lim (dir=0) or 0 (dir=1); state stays CUENTA; done<=1.
  - tc==1, mode=1: cuenta held; state<=FIN; done<=1.
- EN=0 in CUENTA: cuenta held, done<=0.
- FIN:
  - cuenta held; EN, dir and mode changes ignored; done<=0 after its single pulse.
  - Exit only via load or reset.
- done: high exactly one cycle, in the cycle after the edge that performed the terminal step. Never high two consecutive cycles unless two terminal steps occur back to back.
  - Example: lim=0, mode=0, dir=0 gives done every cycle while EN=1.
- Counting up from a value above lim wraps through 2**BITS-1 -> 0 and continues until cuenta==lim. No error is flagged.
- Direction change mid-count: applies from the next step. tc re-evaluates immediately for the new dir.
- lim change: applies immediately to tc and to the next reload.
- activo = (state==CUENTA). Reset value 1.
- Latency: load, step and reload are each 1 cycle; done lags the terminal step by 0 cycles, i.e. it is registered with the step.

Optional Feature:
Macro CONTADOR_PRESCALER_EN.
- Defined:
  - Adds parameter PRESC (default 4, >=1) and an internal prescaler counter of width clog2(PRESC)+1.
  - A step (including the terminal/reload step) occurs only on every PRESC-th cycle with EN=1 in CUENTA.
  - Prescaler is cleared by reset and load, and holds while EN=0.
  - Adds output tick (1 bit, combinational), high on cycles where a step occurs.
- Undefined: no PRESC, no tick port, no prescaler logic; every EN=1 cycle is a step as described above.

Test Plan:
- Reset: BITS=3, rst=0 one edge then 1 -> cuenta=7, done=0, activo=1. EN=1, dir=0 for 7 cycles -> cuenta 6,5,...,0, tc=1 at 0.
- Wrap down: lim=5, mode=0, dir=0, load_val=2 + load, then EN=1 -> cuenta 2,1,0,5,4. done pulses exactly one cycle, coincident with cuenta=5.
- One-shot up: lim=3, mode=1, dir=1, load_val=0, EN=1 held -> cuenta 0,1,2,3, then done=1 one cycle. State FIN, activo=0, cuenta stays 3 for 5 more EN cycles. A load of 6 -> cuenta=6, activo=1.
- Priority: load=1, EN=1, load_val=4 same edge -> cuenta=4, no step. rst=0 with load=1 -> cuenta=7.
- Up past limit: lim=2, dir=1, mode=0, load_val=6, EN=1 -> 6,7,0,1,2,0, done with the 2->0 reload.
- Prescaler (CONTADOR_PRESCALER_EN, PRESC=4): EN=1 from cuenta=7, dir=0 -> cuenta decrements every 4th cycle; tick high one cycle per step. Dropping EN for 2 cycles mid-period delays the step by 2 cycles.
